// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: instruction fetch and load/store share one memory port.
// Data wins a bounded burst while a fetch waits; a single transaction is outstanding at a time.
module mem_port_arbiter #(
    parameter int unsigned MAX_D_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic [31:0] if_rdata,
    output logic        if_rvalid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_gnt,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid
);

    typedef enum logic [1:0] {StIdle, StCmd, StRwait} state_e;

    localparam logic [2:0] MaxBurst = 3'(MAX_D_BURST);

    state_e      state_q, state_d;
    logic        owner_q;  // 1 = data port owns the transaction
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [2:0]  burst_cnt_q;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;
    logic        if_rvalid_q;
    logic        d_done_q;
    logic        d_win;

    assign d_win = d_req && (!if_req || (burst_cnt_q < MaxBurst));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (d_req || if_req) state_d = StCmd;
            StCmd:   if (mem_ready) state_d = we_q ? StIdle : StRwait;
            StRwait: if (mem_rvalid) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        d_gnt     = (state_q == StIdle) && d_win;
        if_gnt    = (state_q == StIdle) && !d_win && if_req;
        mem_read  = (state_q == StCmd) && !we_q;
        mem_write = (state_q == StCmd) && we_q;
        mem_wstrb = mem_write ? wstrb_q : 4'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            burst_cnt_q <= 3'd0;
            if_rdata_q  <= 32'h0;
            d_rdata_q   <= 32'h0;
            if_rvalid_q <= 1'b0;
            d_done_q    <= 1'b0;
        end else begin
            if (d_gnt) begin
                owner_q     <= 1'b1;
                we_q        <= d_we;
                addr_q      <= d_addr;
                wdata_q     <= d_we ? d_wdata : 32'h0;
                wstrb_q     <= d_we ? d_wstrb : 4'h0;
                burst_cnt_q <= if_req ? burst_cnt_q + 3'd1 : 3'd0;
            end else if (if_gnt) begin
                owner_q     <= 1'b0;
                we_q        <= 1'b0;
                addr_q      <= if_addr;
                wdata_q     <= 32'h0;
                wstrb_q     <= 4'h0;
                burst_cnt_q <= 3'd0;
            end
            if ((state_q == StRwait) && mem_rvalid) begin
                if (owner_q) begin
                    d_rdata_q <= mem_rdata;
                end else begin
                    if_rdata_q <= mem_rdata;
                end
            end
            if_rvalid_q <= (state_q == StRwait) && mem_rvalid && !owner_q;
            d_done_q    <= ((state_q == StCmd) && mem_ready && we_q) ||
                           ((state_q == StRwait) && mem_rvalid && owner_q);
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_rvalid = if_rvalid_q;
    assign d_done    = d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_gnt;
    logic [31:0] if_rdata;
    logic        if_rvalid;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [3:0]  d_wstrb = 4'h0;
    logic        d_gnt;
    logic [31:0] d_rdata;
    logic        d_done;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_rvalid = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_D_BURST(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rdata   (if_rdata),
        .if_rvalid  (if_rvalid),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_wstrb    (d_wstrb),
        .d_gnt      (d_gnt),
        .d_rdata    (d_rdata),
        .d_done     (d_done),
        .mem_addr   (mem_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] all_out;
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        all_out = if_rdata | d_rdata | mem_addr | mem_wdata |
                  {24'h0, if_gnt, if_rvalid, d_gnt, d_done, mem_read, mem_write, 2'b00} |
                  {28'h0, mem_wstrb};
        checks++;
        if (all_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got %08h want 00000000", all_out);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        if_req  = 1'b1;
        if_addr = 32'h100;
        @(negedge clk);
        checks++;
        if ({if_gnt, d_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL fetch_gnt got %b want 10", {if_gnt, d_gnt});
        end
        tick();
        if_req    = 1'b0;
        if_addr   = 32'h0;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_read, mem_write, mem_addr, mem_wstrb} !== {2'b10, 32'h100, 4'h0}) begin
            errors++;
            $display("FAIL fetch_cmd got rd=%b wr=%b addr=%08h strb=%h want 1 0 00000100 0",
                     mem_read, mem_write, mem_addr, mem_wstrb);
        end
        tick();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if ({mem_read, if_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_rwait got rd=%b rvalid=%b want 0 0", mem_read, if_rvalid);
        end
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        @(negedge clk);
        checks++;
        if ({if_rvalid, d_done, if_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL fetch_rvalid got rv=%b done=%b data=%08h want 1 0 deadbeef",
                     if_rvalid, d_done, if_rdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if (if_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_pulse_width got %b want 0", if_rvalid);
        end
        tick();
    endtask

    task automatic test_store(input logic [3:0] strb, input int delay);
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h200;
        d_wdata = 32'h12345678;
        d_wstrb = strb;
        @(negedge clk);
        checks++;
        if ({if_gnt, d_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL store_gnt got %b want 01", {if_gnt, d_gnt});
        end
        tick();
        // Changed request fields must not leak into the held command.
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'hFFFF_FFFF;
        d_wdata = 32'h0;
        d_wstrb = 4'hF;
        for (int k = 0; k <= delay; k++) begin
            mem_ready = (k == delay);
            @(negedge clk);
            checks++;
            if ({mem_write, mem_read, d_done, mem_addr, mem_wdata, mem_wstrb} !==
                {3'b100, 32'h200, 32'h12345678, strb}) begin
                errors++;
                $display("FAIL store_cmd_%0d got wr=%b rd=%b done=%b a=%08h d=%08h s=%h",
                         k, mem_write, mem_read, d_done, mem_addr, mem_wdata, mem_wstrb);
            end
            tick();
        end
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({d_done, mem_write, if_rvalid} !== 3'b100) begin
            errors++;
            $display("FAIL store_done got done=%b wr=%b rv=%b want 1 0 0",
                     d_done, mem_write, if_rvalid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (d_done !== 1'b0) begin
            errors++;
            $display("FAIL store_done_width got %b want 0", d_done);
        end
        tick();
    endtask

    task automatic test_burst();
        string pattern;
        logic  prev_d;
        pattern = "DDDDFDDDDF";
        prev_d  = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h400;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h800;
        for (int g = 0; g < 10; g++) begin
            @(negedge clk);
            checks++;
            if ({d_gnt, if_gnt} !== ((pattern[g] == "D") ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL burst_gnt_%0d got d=%b f=%b want %s", g, d_gnt, if_gnt,
                         (pattern[g] == "D") ? "D" : "F");
            end
            if (g > 0) begin
                checks++;
                if ({d_done, if_rvalid} !== (prev_d ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL burst_pulse_%0d got done=%b rv=%b", g, d_done, if_rvalid);
                end
            end
            prev_d = (pattern[g] == "D");
            tick();
            mem_ready = 1'b1;
            tick();
            mem_ready  = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hA000_0000 + g;
            tick();
            mem_rvalid = 1'b0;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);
        checks++;
        if ({if_rvalid, if_rdata, d_rdata} !== {1'b1, 32'hA000_0009, 32'hA000_0008}) begin
            errors++;
            $display("FAIL burst_last got rv=%b if=%08h d=%08h want 1 a0000009 a0000008",
                     if_rvalid, if_rdata, d_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h300;
        tick();
        d_req     = 1'b0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        rst       = 1'b1;
        tick();
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        checks++;
        if ({d_done, if_rvalid, mem_read, mem_addr, d_rdata} !== {3'b000, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL rstmid_outputs got done=%b rv=%b rd=%b a=%08h d=%08h",
                     d_done, if_rvalid, mem_read, mem_addr, d_rdata);
        end
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        if_req     = 1'b1;
        if_addr    = 32'h500;
        @(negedge clk);
        checks++;
        if ({d_done, d_rdata, if_gnt} !== {1'b0, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_late got done=%b d=%08h gnt=%b want 0 00000000 1",
                     d_done, d_rdata, if_gnt);
        end
        tick();
        if_req    = 1'b0;
        mem_ready = 1'b1;
        tick();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        tick();
        mem_rvalid = 1'b0;
        tick();
    endtask

    task automatic test_stray();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        mem_ready  = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        mem_ready  = 1'b0;
        @(negedge clk);
        checks++;
        if ({if_rvalid, d_done, mem_read, mem_write, if_rdata} !== {4'b0000, 32'h5555_AAAA}) begin
            errors++;
            $display("FAIL stray_idle got rv=%b done=%b rd=%b wr=%b if=%08h",
                     if_rvalid, d_done, mem_read, mem_write, if_rdata);
        end
        if_req  = 1'b1;
        if_addr = 32'h600;
        tick();
        if_req    = 1'b0;
        mem_ready = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            tick();
            @(negedge clk);
            checks++;
            if ({if_rvalid, d_done, mem_read, if_gnt} !== 4'b0000) begin
                errors++;
                $display("FAIL stray_rwait_%0d got rv=%b done=%b rd=%b gnt=%b",
                         k, if_rvalid, d_done, mem_read, if_gnt);
            end
        end
        tick();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_8888;
        tick();
        mem_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'h7777_8888}) begin
            errors++;
            $display("FAIL stray_resume got rv=%b if=%08h want 1 77778888", if_rvalid, if_rdata);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store(4'b0011, 3);
        test_store(4'b0000, 0);
        test_burst();
        test_reset_mid();
        test_stray();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
